// File: rtl/ringosc_pkg.sv
// Shared definitions for the ring-oscillator frequency counter: FSM encoding,
// default counter width and the timer-width helper.
package ringosc_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_GATE   = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam int DEF_CNT_W = 16;

   // One timer serves both the settle and gate phases, so it is sized for the longer one.
   function automatic int tmr_width(input int gate_cycles, input int settle_cycles);
      int longest;
      longest = (gate_cycles > settle_cycles) ? gate_cycles : settle_cycles;
      return $clog2(longest);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, synchronous active-low reset.
module sync_2ff
   import ringosc_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_p0;
   logic sync_p1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         meta_p0 <= d;
         sync_p1 <= meta_p0;
      end
   end

   assign q = sync_p1;

endmodule

// File: rtl/ringosc_freq_counter.sv
// Ring-oscillator frequency counter: enable, settle, count rising edges over a gate window.
// Define FREQ_CONT_EN for back-to-back measurements while start is held high.
module ringosc_freq_counter
   import ringosc_pkg::*;
#(
   parameter int GATE_CYCLES   = 1024,
   parameter int SETTLE_CYCLES = 16,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             ro_in,
   output logic             ro_en,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);

   localparam int               TMR_W       = tmr_width(GATE_CYCLES, SETTLE_CYCLES);
   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   // Returns {hit_ceiling, next_value}; the value never wraps past CNT_MAX.
   function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      logic [CNT_W:0] r;
      if (!inc)
         r = {1'b0, v};
      else if (v == CNT_MAX)
         r = {1'b1, v};
      else
         r = {1'b0, v + 1'b1};
      return r;
   endfunction

   logic [1:0]       state;
   logic [TMR_W-1:0] timer;
   logic [CNT_W-1:0] edge_cnt;
   logic             sat_flag;
   logic             ro_sync_p1;
   logic             ro_hist_p2;
   logic             ro_edge;
   logic [CNT_W:0]   cnt_step;
   logic             sat_next;

   // Stage p0/p1: bring the oscillator into the clk domain
   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ro_in),
      .q     (ro_sync_p1)
   );

   // Stage p2: history flop for rising-edge detection
   always_ff @(posedge clk) begin
      if (!rst_n)
         ro_hist_p2 <= 1'b0;
      else
         ro_hist_p2 <= ro_sync_p1;
   end

   assign ro_edge  = ro_sync_p1 & ~ro_hist_p2;
   assign cnt_step = sat_inc(edge_cnt, ro_edge);
   assign sat_next = sat_flag | cnt_step[CNT_W];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         timer    <= '0;
         edge_cnt <= '0;
         sat_flag <= 1'b0;
         count    <= '0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_SETTLE;
                  timer <= '0;
               end
            end
            ST_SETTLE: begin
               if (timer == SETTLE_LAST) begin
                  state    <= ST_GATE;
                  timer    <= '0;
                  edge_cnt <= '0;
                  sat_flag <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_GATE: begin
               edge_cnt <= cnt_step[CNT_W-1:0];
               sat_flag <= sat_next;
               // Results are captured on the closing edge so an edge in the last gate cycle still counts
               if (timer == GATE_LAST) begin
                  state    <= ST_DONE;
                  count    <= cnt_step[CNT_W-1:0];
                  overflow <= sat_next;
                  done     <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_DONE: begin
`ifdef FREQ_CONT_EN
               if (start) begin
                  state <= ST_SETTLE;
                  timer <= '0;
               end else begin
                  state <= ST_IDLE;
               end
`else
               state <= ST_IDLE;
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign ro_en = (state == ST_SETTLE) || (state == ST_GATE);
   assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_ringosc_freq_counter.sv
// Scoreboard bench for ringosc_freq_counter: randomized synchronous square waves on ro_in,
// expected results from counting sampled rising transitions over the gate window.
`timescale 1ns/1ps
module tb_ringosc_freq_counter;

   localparam int G    = 64;
   localparam int S    = 16;
   localparam int W    = 4;
   localparam int CMAX = (1 << W) - 1;
`ifdef FREQ_CONT_EN
   localparam bit CONT = 1'b1;
`else
   localparam bit CONT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         ro_in = 1'b0;
   logic         ro_en;
   logic         busy;
   logic         done;
   logic [W-1:0] count;
   logic         overflow;

   ringosc_freq_counter #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .ro_in    (ro_in),
      .ro_en    (ro_en),
      .busy     (busy),
      .done     (done),
      .count    (count),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int acc;
      int dcyc;
      int cnt;
      bit ovf;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   idle_from = 0;
   int   n_chk = 0;
   int   n_err = 0;
   int   held_cnt = 0;
   bit   held_ovf = 1'b0;
   bit   mon_en = 1'b0;

   // ro_in waveform: mode 0 square wave, 1 held low, 2 held high
   int ro_mode = 1;
   int ro_per = 8;
   int ro_hi = 4;
   int ro_ph = 0;

   function automatic bit ro_fn(input int k);
      if (ro_mode == 1) return 1'b0;
      if (ro_mode == 2) return 1'b1;
      return ((k + ro_ph) % ro_per) < ro_hi;
   endfunction

   // Rising transitions of the sampled waveform visible in the gate window ending at done cycle d
   function automatic int model_count(input int d);
      int c;
      c = 0;
      for (int k = d - G - 1; k <= d - 2; k++)
         if (ro_fn(k) && !ro_fn(k - 1)) c++;
      return c;
   endfunction

   task automatic chk(input string nm, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp_v);
      end
   endtask

   task automatic push_meas(input int acc);
      exp_t e;
      int   c;
      e.acc  = acc;
      e.dcyc = acc + S + G + 1;
      c      = model_count(e.dcyc);
      e.ovf  = (c > CMAX);
      e.cnt  = e.ovf ? CMAX : c;
      sb.push_back(e);
      idle_from = e.dcyc + 1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      ro_in = ro_fn(cyc + 1);
   endtask

   // Drive start for the current cycle, note whether the FSM will take it, then advance.
   task automatic tick(input bit s);
      start = s;
      if (s && rst_n && (cyc >= idle_from || (CONT && cyc == idle_from - 1)))
         push_meas(cyc);
      step();
   endtask

   task automatic wait_idle();
      while (cyc < idle_from) tick(1'b0);
      tick(1'b0);
   endtask

   task automatic set_wave(input int mode, input int per, input int hi, input int ph);
      ro_mode = mode;
      ro_per  = per;
      ro_hi   = hi;
      ro_ph   = ph;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         bit eb, er, ed;
         eb = 1'b0;
         er = 1'b0;
         ed = 1'b0;
         if (sb.size() > 0) begin
            eb = (cyc > sb[0].acc) && (cyc <= sb[0].dcyc);
            er = (cyc > sb[0].acc) && (cyc < sb[0].dcyc);
            ed = (cyc == sb[0].dcyc);
         end
         chk("busy", int'(busy), int'(eb));
         chk("ro_en", int'(ro_en), int'(er));
         chk("done", int'(done), int'(ed));
         if (ed) begin
            held_cnt = sb[0].cnt;
            held_ovf = sb[0].ovf;
            void'(sb.pop_front());
         end
         chk("count", int'(count), held_cnt);
         chk("overflow", int'(overflow), int'(held_ovf));
      end
   end

   initial begin
      int acc0;
      rst_n = 1'b0;
      step();
      mon_en = 1'b1;
      step();
      step();
      rst_n = 1'b1;
      idle_from = cyc;
      tick(1'b0);

      // period 8 -> 8 edges; period 4 -> saturates a 4-bit counter
      set_wave(0, 8, 4, 0);
      tick(1'b1);
      wait_idle();
      set_wave(0, 4, 2, 1);
      tick(1'b1);
      wait_idle();

      // constant inputs
      set_wave(1, 8, 4, 0);
      tick(1'b1);
      wait_idle();
      set_wave(2, 8, 4, 0);
      tick(1'b1);
      wait_idle();

      // start re-pulsed during SETTLE and GATE
      set_wave(0, 6, 3, 2);
      acc0 = cyc;
      tick(1'b1);
      while (cyc < acc0 + 5) tick(1'b0);
      tick(1'b1);
      while (cyc < acc0 + S + 20) tick(1'b0);
      tick(1'b1);
      while (cyc < idle_from - 1) tick(1'b0);
      // start in the DONE cycle, then the following cycle
      tick(1'b1);
      tick(1'b1);
      wait_idle();

      // reset mid-gate, then a fresh measurement
      set_wave(0, 5, 2, 0);
      acc0 = cyc;
      tick(1'b1);
      while (cyc < acc0 + S + 10) tick(1'b0);
      rst_n = 1'b0;
      tick(1'b0);
      rst_n = 1'b1;
      sb.delete();
      held_cnt = 0;
      held_ovf = 1'b0;
      idle_from = cyc;
      tick(1'b0);
      set_wave(0, 8, 4, 3);
      tick(1'b1);
      wait_idle();

      // start held across several windows
      set_wave(0, 8, 5, 1);
      for (int i = 0; i < 2 * (S + G + 1) + 20; i++) tick(1'b1);
      wait_idle();

      // randomized waveforms and gaps
      for (int n = 0; n < 20; n++) begin
         int per;
         per = $urandom_range(12, 3);
         set_wave(($urandom_range(9, 0) == 0) ? int'($urandom_range(2, 1)) : 0,
                  per, $urandom_range(per - 1, 1), $urandom_range(per - 1, 0));
         for (int g = 0; g < int'($urandom_range(4, 0)); g++) tick(1'b0);
         tick(1'b1);
         if ($urandom_range(1, 0) == 1) begin
            for (int g = 0; g < int'($urandom_range(60, 1)); g++) tick(1'b0);
            tick(1'b1);
         end
         wait_idle();
      end

      for (int i = 0; i < 500 && sb.size() > 0; i++) tick(1'b0);
      chk("drain", sb.size(), 0);
      tick(1'b0);
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
